// File: rtl/num_pkg.sv
// Shared definitions for the num_* arithmetic blocks: divider FSM states,
// counter sizing and signed saturation bounds.
package num_pkg;

  localparam int NUM_MAXW = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } num_div_state_e;

  // Width of a counter that must reach the value n inclusive.
  function automatic int num_cnt_width(input int n);
    return (n < 32'sd1) ? 32'sd1 : $clog2(n + 32'sd1);
  endfunction

  function automatic logic signed [NUM_MAXW-1:0] num_smax_val(input int width);
    logic signed [NUM_MAXW-1:0] one_v;
    one_v = {{(NUM_MAXW-1){1'b0}}, 1'b1};
    return (one_v <<< (width - 32'sd1)) - one_v;
  endfunction

  function automatic logic signed [NUM_MAXW-1:0] num_smin_val(input int width);
    return ~num_smax_val(width);
  endfunction

endpackage

// File: rtl/num_udiv_core.sv
// Unsigned restoring division core: start loads the operands, each step
// resolves one quotient bit MSB first, last flags that every bit is resolved.
module num_udiv_core
  import num_pkg::*;
#(
  parameter int DVD_WIDTH = 32,
  parameter int DVS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic [DVD_WIDTH-1:0] dvd,
  input  logic [DVS_WIDTH-1:0] dvs,
  output logic [DVD_WIDTH-1:0] q,
  output logic                 last
);

  localparam int CNT_WIDTH = num_cnt_width(DVD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_END = CNT_WIDTH'(DVD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

  logic [DVD_WIDTH-1:0] dvd_r;
  logic [DVD_WIDTH-1:0] q_r;
  logic [DVS_WIDTH-1:0] dvs_r;
  logic [DVS_WIDTH-1:0] rem_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic [DVS_WIDTH:0]   rem_shift_s;
  logic [DVS_WIDTH:0]   rem_diff_s;
  logic [DVS_WIDTH-1:0] rem_nx_s;
  logic                 fit_s;
  logic                 last_s;

  // Trial subtraction; a clear borrow bit means the divisor fits.
  always_comb begin
    rem_shift_s = {rem_r, dvd_r[DVD_WIDTH-1]};
    rem_diff_s  = rem_shift_s - {1'b0, dvs_r};
    fit_s       = ~rem_diff_s[DVS_WIDTH];
    if (fit_s) begin
      rem_nx_s = rem_diff_s[DVS_WIDTH-1:0];
    end else begin
      rem_nx_s = rem_shift_s[DVS_WIDTH-1:0];
    end
  end

  assign last_s = (count_r == CNT_END);

  // Operand, partial remainder, quotient and step-count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dvd_r   <= '0;
      dvs_r   <= '0;
      rem_r   <= '0;
      q_r     <= '0;
      count_r <= '0;
    end else if (start) begin
      dvd_r   <= dvd;
      dvs_r   <= dvs;
      rem_r   <= '0;
      q_r     <= '0;
      count_r <= '0;
    end else if (step && !last_s) begin
      dvd_r   <= dvd_r << 1'b1;
      rem_r   <= rem_nx_s;
      q_r     <= (q_r << 1'b1) | DVD_WIDTH'(fit_s);
      count_r <= count_r + CNT_ONE;
    end
  end

  assign q    = q_r;
  assign last = last_s;

endmodule

// File: rtl/num_sdiv.sv
// Iterative signed fixed-point divider, out = trunc(left * 2^OUT_LSB / right),
// with go/done handshake. Define NUM_SDIV_SAT_EN for saturating overflow.
module num_sdiv
  import num_pkg::*;
#(
  parameter int LEFT_WIDTH  = 32,
  parameter int RIGHT_WIDTH = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int OUT_LSB     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [LEFT_WIDTH-1:0]  left,
  input  logic [RIGHT_WIDTH-1:0] right,
  output logic [OUT_WIDTH-1:0]   out,
  output logic                   done
);

  localparam int N  = LEFT_WIDTH + OUT_LSB;
  localparam int QW = N + 1;

  num_div_state_e          state_r;
  num_div_state_e          state_nx_s;
  logic                    neg_r;
  logic                    dz_r;
  logic                    done_r;
  logic [OUT_WIDTH-1:0]    out_r;
  logic [OUT_WIDTH-1:0]    out_nx_s;
  logic [LEFT_WIDTH-1:0]   left_mag_s;
  logic [RIGHT_WIDTH-1:0]  right_mag_s;
  logic [N-1:0]            dvd_s;
  logic [N-1:0]            q_s;
  logic                    start_s;
  logic                    step_s;
  logic                    last_s;
  logic signed [QW-1:0]    q_signed_s;

`ifdef NUM_SDIV_SAT_EN
  localparam logic signed [NUM_MAXW-1:0] SMAX = num_smax_val(OUT_WIDTH);
  localparam logic signed [NUM_MAXW-1:0] SMIN = num_smin_val(OUT_WIDTH);
  logic                        left_neg_r;
  logic signed [NUM_MAXW-1:0]  q_wide_s;
`endif

  // Magnitudes are unsigned, so the most-negative operand still fits.
  assign left_mag_s  = left[LEFT_WIDTH-1] ? -left : left;
  assign right_mag_s = right[RIGHT_WIDTH-1] ? -right : right;
  assign dvd_s       = N'(left_mag_s) << OUT_LSB;

  num_udiv_core #(
    .DVD_WIDTH (N),
    .DVS_WIDTH (RIGHT_WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .step  (step_s),
    .dvd   (dvd_s),
    .dvs   (right_mag_s),
    .q     (q_s),
    .last  (last_s)
  );

  // Handshake FSM next state and core controls; dropping go aborts.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (go) begin
          state_nx_s = RUN;
          start_s    = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        step_s = go;
        if (!go) begin
          state_nx_s = IDLE;
        end else if (last_s) begin
          state_nx_s = FIXUP;
        end else begin
          state_nx_s = RUN;
        end
      end
      FIXUP: begin
        if (go) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Sign restoration and overflow / divide-by-zero policy.
  always_comb begin
    if (neg_r) begin
      q_signed_s = -$signed({1'b0, q_s});
    end else begin
      q_signed_s = $signed({1'b0, q_s});
    end
`ifdef NUM_SDIV_SAT_EN
    q_wide_s = NUM_MAXW'(q_signed_s);
    if (dz_r) begin
      out_nx_s = left_neg_r ? OUT_WIDTH'(SMIN) : OUT_WIDTH'(SMAX);
    end else if (q_wide_s > SMAX) begin
      out_nx_s = OUT_WIDTH'(SMAX);
    end else if (q_wide_s < SMIN) begin
      out_nx_s = OUT_WIDTH'(SMIN);
    end else begin
      out_nx_s = OUT_WIDTH'(q_wide_s);
    end
`else
    if (dz_r) begin
      out_nx_s = '1;
    end else begin
      out_nx_s = OUT_WIDTH'(q_signed_s);
    end
`endif
  end

  // State, operand flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      neg_r      <= 1'b0;
      dz_r       <= 1'b0;
      out_r      <= '0;
      done_r     <= 1'b0;
`ifdef NUM_SDIV_SAT_EN
      left_neg_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      done_r  <= (state_nx_s == DONE);
      if (start_s) begin
        neg_r      <= left[LEFT_WIDTH-1] ^ right[RIGHT_WIDTH-1];
        dz_r       <= (right == '0);
`ifdef NUM_SDIV_SAT_EN
        left_neg_r <= left[LEFT_WIDTH-1];
`endif
      end
      if ((state_r == FIXUP) && go) begin
        out_r <= out_nx_s;
      end
    end
  end

  assign out  = out_r;
  assign done = done_r;

endmodule

// File: tb/tb_num_sdiv.sv
// Directed bench for num_sdiv: an 8/8/8 integer instance and an 8/8/12 Q.4
// instance, checked every cycle against an arithmetic model of the quotient.
module tb_num_sdiv;

`ifdef NUM_SDIV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int N8  = 8;
  localparam int N12 = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        go8, go12;
  logic [7:0]  l8, r8, l12, r12;
  logic [7:0]  out8;
  logic [11:0] out12;
  logic        done8, done12;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          done_at [2];
  logic [15:0] pend [2];
  logic [15:0] lit [2];
  logic [15:0] exp_out [2];

  always #5 clk = ~clk;

  num_sdiv #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .OUT_WIDTH(8), .OUT_LSB(0)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .left(l8), .right(r8), .out(out8), .done(done8)
  );

  num_sdiv #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .OUT_WIDTH(12), .OUT_LSB(4)) dut12 (
    .clk(clk), .reset(reset), .go(go12), .left(l12), .right(r12), .out(out12), .done(done12)
  );

  // Real-number rule: truncate a*2^lsb/b toward zero, then wrap or clamp to ow bits.
  function automatic logic [15:0] model(input int a, input int b, input int ow, input int lsb);
    longint num, q, smax, smin, m;
    smax = (64'sd1 <<< (ow - 1)) - 64'sd1;
    smin = -smax - 64'sd1;
    if (b == 0) begin
      if (SAT) q = (a >= 0) ? smax : smin;
      else     q = -64'sd1;
    end else begin
      num = longint'(a) * (64'sd1 <<< lsb);
      q   = num / longint'(b);
      if (SAT && q > smax) q = smax;
      if (SAT && q < smin) q = smin;
    end
    m = (64'sd1 <<< ow) - 64'sd1;
    return 16'(q & m);
  endfunction

  function automatic logic [15:0] dut_out(input int i);
    return (i == 0) ? 16'(out8) : 16'(out12);
  endfunction

  function automatic logic dut_done(input int i);
    return (i == 0) ? done8 : done12;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    logic rs;
    rs = reset;
    cyc++;
    #1;
    if (!rs) begin
      chk_en = 1'b1;
      exp_out[0] = 16'h0;
      exp_out[1] = 16'h0;
    end
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic ed;
        ed = (cyc == done_at[i]);
        if (ed) begin
          exp_out[i] = pend[i];
          chk(i == 0 ? "model8_vs_hand" : "model12_vs_hand", pend[i], lit[i]);
          chk(i == 0 ? "out8_vs_hand" : "out12_vs_hand", dut_out(i), lit[i]);
        end
        chk(i == 0 ? "out8" : "out12", dut_out(i), exp_out[i]);
        chk(i == 0 ? "done8" : "done12", 16'(dut_done(i)), 16'(ed));
      end
    end
  end

  task automatic set_go(input int i, input logic v);
    if (i == 0) go8 = v;
    else        go12 = v;
  endtask

  task automatic launch(input int i, input int a, input int b, input logic [15:0] l);
    @(negedge clk);
    if (i == 0) begin
      l8 = a[7:0]; r8 = b[7:0]; go8 = 1'b1;
    end else begin
      l12 = a[7:0]; r12 = b[7:0]; go12 = 1'b1;
    end
    done_at[i] = cyc + ((i == 0) ? N8 : N12) + 3;
    pend[i]    = model(a, b, (i == 0) ? 8 : 12, (i == 0) ? 0 : 4);
    lit[i]     = l;
  endtask

  task automatic abort_go(input int i);
    set_go(i, 1'b0);
    done_at[i] = -1;
  endtask

  task automatic op(input int i, input int a, input int b, input logic [15:0] l);
    int k;
    launch(i, a, b, l);
    @(negedge clk);
    if (i == 0) begin l8 = 8'($urandom); r8 = 8'($urandom); end
    else        begin l12 = 8'($urandom); r12 = 8'($urandom); end
    k = 0;
    while (!dut_done(i) && k < 64) begin
      @(negedge clk);
      k++;
    end
    set_go(i, 1'b0);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    go8 = 1'b0; go12 = 1'b0;
    done_at[0] = -1; done_at[1] = -1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    go8 = 1'b0; go12 = 1'b0;
    l8 = 8'h0; r8 = 8'h0; l12 = 8'h0; r12 = 8'h0;
    done_at[0] = -1; done_at[1] = -1;
    pend[0] = 16'h0; pend[1] = 16'h0;
    lit[0] = 16'h0; lit[1] = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    op(0, 100, 7, 16'h0E);
    op(0, -100, 7, 16'hF2);
    op(0, -100, -7, 16'h0E);
    op(0, -128, -1, SAT ? 16'h7F : 16'h80);
    op(0, 5, 0, SAT ? 16'h7F : 16'hFF);
    op(0, -5, 0, SAT ? 16'h80 : 16'hFF);
    op(0, 0, 0, SAT ? 16'h7F : 16'hFF);
    op(0, 127, -128, 16'h00);
    op(0, -128, 1, 16'h80);
    op(0, -128, 127, 16'hFF);

    op(1, 3, 2, 16'h018);
    op(1, -3, 2, 16'hFE8);
    op(1, 127, 1, 16'h7F0);
    op(1, -128, 1, 16'h800);
    op(1, -128, -1, SAT ? 16'h7FF : 16'h800);
    op(1, 1, 3, 16'h005);
    op(1, -1, 3, 16'hFFB);
    op(1, 5, 0, SAT ? 16'h7FF : 16'hFFF);

    // Reset mid-run clears both instances, then a full-latency retry.
    launch(0, 100, 7, 16'h0E);
    repeat (4) @(negedge clk);
    pulse_reset();
    @(negedge clk);
    op(0, 100, 7, 16'h0E);

    // go dropped mid-run: no done, previous result held.
    op(0, -100, 7, 16'hF2);
    launch(0, 50, 3, 16'h10);
    repeat (4) @(negedge clk);
    abort_go(0);
    repeat (20) @(negedge clk);

    // go dropped during FIXUP: out must not be written.
    op(1, 1, 3, 16'h005);
    launch(1, 3, 2, 16'h018);
    repeat (N12 + 2) @(negedge clk);
    abort_go(1);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
